// File: rtl/qtree_nat_serializer_pkg.sv
// mMapAdd_package: shared types for the QTree_Nat heap serializer.
//   QTree_Nat_t          heap node word: payload above a 2-bit tag in [1:0]
//   Pointer_QTree_Nat_t  heap address
//   QNode layout         child i occupies payload[i*PTR_W +: PTR_W]
//   QVal layout          value occupies payload[VAL_W-1:0] (word bits [VAL_W+1:2])
// Optional feature macro: QTREE_SER_FREE_EN adds the FREE state to the FSM enum.
package mMapAdd_package;

  localparam int PTR_W       = 16;
  localparam int VAL_W       = 32;
  localparam int CHILD_W     = 4 * PTR_W;
  localparam int PAYLOAD_W   = (CHILD_W > VAL_W) ? CHILD_W : VAL_W;
  localparam int QTREE_NAT_W = PAYLOAD_W + 2;

  localparam logic [1:0] QNONE  = 2'd0;
  localparam logic [1:0] QVAL   = 2'd1;
  localparam logic [1:0] QNODE  = 2'd2;
  localparam logic [1:0] QERROR = 2'd3;

  typedef logic [PTR_W-1:0] Pointer_QTree_Nat_t;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [1:0]           tag;
  } QTree_Nat_t;

  // One traversal stack entry: node address, node word, next child to visit.
  typedef struct packed {
    Pointer_QTree_Nat_t ptr;
    QTree_Nat_t         node;
    logic [2:0]         idx;
  } stack_entry_t;

`ifdef QTREE_SER_FREE_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_NEXT, S_FREE} ser_state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_NEXT} ser_state_e;
`endif

  // Emitted QNode words keep their tag but drop the child pointers.
  function automatic QTree_Nat_t QNode_Nat_strip(input QTree_Nat_t n);
    QTree_Nat_t r;
    r         = n;
    r.payload = '0;
    return r;
  endfunction

  function automatic Pointer_QTree_Nat_t qnode_child(input QTree_Nat_t n, input logic [1:0] idx);
    return n.payload[idx*PTR_W +: PTR_W];
  endfunction

endpackage

// File: rtl/qtree_nat_serializer_if.sv
// Handshake bundle of qtree_nat_serializer.
//   root_*    root pointer offer (valid/ready)
//   rd_req_*  heap read request; rd_rsp_* heap read response (no backpressure)
//   o_t*      AXI-stream output, tlast on the final word of a tree
//   busy, overflow status
//   free_*    node release port (only with QTREE_SER_FREE_EN)
// master = serializer side, slave = environment side.
interface qtree_nat_serializer_if;
  import mMapAdd_package::*;

  logic                     root_valid;
  logic                     root_ready;
  Pointer_QTree_Nat_t       root_ptr;
  logic                     rd_req_valid;
  logic                     rd_req_ready;
  Pointer_QTree_Nat_t       rd_req_addr;
  logic                     rd_rsp_valid;
  logic [QTREE_NAT_W-1:0]   rd_rsp_data;
  logic [QTREE_NAT_W-1:0]   o_tdata;
  logic                     o_tvalid;
  logic                     o_tready;
  logic                     o_tlast;
  logic                     busy;
  logic                     overflow;
`ifdef QTREE_SER_FREE_EN
  logic                     free_valid;
  logic                     free_ready;
  Pointer_QTree_Nat_t       free_addr;
`endif

  modport master (
    input  root_valid, root_ptr, rd_req_ready, rd_rsp_valid, rd_rsp_data, o_tready,
`ifdef QTREE_SER_FREE_EN
    input  free_ready,
    output free_valid, free_addr,
`endif
    output root_ready, rd_req_valid, rd_req_addr, o_tdata, o_tvalid, o_tlast, busy, overflow
  );

  modport slave (
    output root_valid, root_ptr, rd_req_ready, rd_rsp_valid, rd_rsp_data, o_tready,
`ifdef QTREE_SER_FREE_EN
    output free_ready,
    input  free_valid, free_addr,
`endif
    input  root_ready, rd_req_valid, rd_req_addr, o_tdata, o_tvalid, o_tlast, busy, overflow
  );

endinterface

// File: rtl/qtree_ser_stack.sv
// qtree_ser_stack: DEPTH-entry LIFO of {ptr, node, idx} for the tree walk.
//   clr_i      drop all entries (abandoned traversal)
//   push_i     push push_data_i (ignored when full)
//   pop_i      drop the top entry
//   upd_idx_i  overwrite the top entry's idx with idx_i
//   top_o      combinational view of the top entry; full_o/empty_o flags
module qtree_ser_stack
  import mMapAdd_package::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         clr_i,
  input  logic         push_i,
  input  stack_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         upd_idx_i,
  input  logic [2:0]   idx_i,
  output stack_entry_t top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  stack_entry_t  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign wr_idx  = AW'(cnt_q);
  assign top_idx = AW'(cnt_q - CW'(1));
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign top_o   = mem_q[top_idx];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (push_i && !full_o) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // NOTE: the storage array has no reset; only cnt_q decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= push_data_i;
    end else if (upd_idx_i) begin
      mem_q[top_idx].idx <= idx_i;
    end
  end

endmodule

// File: rtl/qtree_nat_serializer.sv
// qtree_nat_serializer: walks a QTree_Nat heap from a root pointer and streams
// every node in postfix order (c0..c3, then the parent) on an AXI stream.
//   clk, aresetn  clock, asynchronous active-low reset
//   bus           qtree_nat_serializer_if.master (root, heap read, stream, status)
// Parameter DEPTH: traversal stack entries = deepest supported QNode nesting.
// Optional feature macro: QTREE_SER_FREE_EN releases each emitted node's address
// on the free port before continuing.
module qtree_nat_serializer
  import mMapAdd_package::*;
#(
  parameter int DEPTH = 16
) (
  input logic                    clk,
  input logic                    aresetn,
  qtree_nat_serializer_if.master bus
);

  ser_state_e         state_q, state_d;
  Pointer_QTree_Nat_t addr_q, addr_d;
  QTree_Nat_t         word_q, word_d;
  logic               err_q, err_d;
  logic               overflow_q, overflow_d;
`ifdef QTREE_SER_FREE_EN
  Pointer_QTree_Nat_t node_addr_q, node_addr_d;
`endif

  logic         stk_clr, stk_push, stk_pop, stk_upd, stk_full, stk_empty;
  logic [2:0]   stk_idx;
  stack_entry_t stk_push_data, stk_top;
  QTree_Nat_t   rsp;

  assign rsp = QTree_Nat_t'(bus.rd_rsp_data);

  qtree_ser_stack #(.DEPTH(DEPTH)) u_stack (
    .clk        (clk),
    .aresetn    (aresetn),
    .clr_i      (stk_clr),
    .push_i     (stk_push),
    .push_data_i(stk_push_data),
    .pop_i      (stk_pop),
    .upd_idx_i  (stk_upd),
    .idx_i      (stk_idx),
    .top_o      (stk_top),
    .full_o     (stk_full),
    .empty_o    (stk_empty)
  );

  always_comb begin
    // NOTE: every signal gets its default first, so no branch can infer a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    word_d        = word_q;
    err_d         = err_q;
    overflow_d    = overflow_q;
`ifdef QTREE_SER_FREE_EN
    node_addr_d   = node_addr_q;
`endif
    stk_clr       = 1'b0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_upd       = 1'b0;
    stk_idx       = stk_top.idx + 3'd1;
    stk_push_data = '{ptr: addr_q, node: rsp, idx: 3'd0};

    case (state_q)
      S_IDLE: begin
        if (bus.root_valid) begin
          addr_d     = bus.root_ptr;
          overflow_d = 1'b0;
          err_d      = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.rd_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rd_rsp_valid) begin
          if (rsp.tag == QNODE) begin
            if (stk_full) begin
              // Too deep: report once with a QError word and drop the walk.
              overflow_d = 1'b1;
              err_d      = 1'b1;
              word_d     = '{payload: '0, tag: QERROR};
              state_d    = S_EMIT;
            end else begin
              stk_push = 1'b1;
              state_d  = S_NEXT;
            end
          end else begin
            word_d  = rsp;
`ifdef QTREE_SER_FREE_EN
            node_addr_d = addr_q;
`endif
            state_d = S_EMIT;
          end
        end
      end
      S_NEXT: begin
        if (stk_top.idx[2]) begin
          // All four children done: the parent itself is next in postfix order.
          stk_pop = 1'b1;
          word_d  = QNode_Nat_strip(stk_top.node);
`ifdef QTREE_SER_FREE_EN
          node_addr_d = stk_top.ptr;
`endif
          state_d = S_EMIT;
        end else begin
          addr_d  = qnode_child(stk_top.node, stk_top.idx[1:0]);
          stk_upd = 1'b1;
          state_d = S_REQ;
        end
      end
      S_EMIT: begin
        if (bus.o_tready) begin
          if (err_q) begin
            stk_clr = 1'b1;
            state_d = S_IDLE;
          end else begin
`ifdef QTREE_SER_FREE_EN
            state_d = S_FREE;
`else
            state_d = stk_empty ? S_IDLE : S_NEXT;
`endif
          end
        end
      end
`ifdef QTREE_SER_FREE_EN
      S_FREE: begin
        if (bus.free_ready) state_d = stk_empty ? S_IDLE : S_NEXT;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef QTREE_SER_FREE_EN
      node_addr_q <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so all update together at the edge.
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      err_q       <= err_d;
      overflow_q  <= overflow_d;
`ifdef QTREE_SER_FREE_EN
      node_addr_q <= node_addr_d;
`endif
    end
  end

  assign bus.root_ready   = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.rd_req_valid = (state_q == S_REQ);
  assign bus.rd_req_addr  = addr_q;
  assign bus.o_tvalid     = (state_q == S_EMIT);
  assign bus.o_tdata      = word_q;
  // The stack is already popped when a parent reaches EMIT, so empty means root.
  assign bus.o_tlast      = (state_q == S_EMIT) && (err_q || stk_empty);
  assign bus.overflow     = overflow_q;

`ifdef QTREE_SER_FREE_EN
  assign bus.free_valid   = (state_q == S_FREE);
  assign bus.free_addr    = node_addr_q;
`else
  // Entry addresses only matter for the free port; keep them visibly sunk.
  logic unused_stk_ptr;
  assign unused_stk_ptr = ^stk_top.ptr;
`endif

endmodule

// File: tb/tb_qtree_nat_serializer.sv
module tb_qtree_nat_serializer;
  import mMapAdd_package::*;

  localparam int TB_DEPTH = 2;
  localparam int W        = QTREE_NAT_W;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  qtree_nat_serializer_if bus ();
  qtree_nat_serializer #(.DEPTH(TB_DEPTH)) dut (.clk(clk), .aresetn(aresetn), .bus(bus));

  // Heap and environment knobs.
  logic [W-1:0] heap [256];
  int  rd_lat     = 1;
  bit  req_rand   = 0;
  bit  out_rand   = 0;
  int  free_delay = 0;
  int  lat_cnt    = 0;
  logic [15:0] pend_addr;

  // Observed and expected traffic.
  logic [W-1:0] got_w[$];
  bit           got_l[$];
  logic [15:0]  got_rd[$];
  logic [15:0]  got_fr[$];
  logic [W-1:0] exp_w[$];
  logic [15:0]  exp_rd[$];
  logic [15:0]  exp_fr[$];
  bit           exp_ovf;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_val(input logic [31:0] v);
    return {{(W-34){1'b0}}, v, 2'd1};
  endfunction

  function automatic logic [W-1:0] mk_node(input logic [15:0] a, b, c, d);
    return {d, c, b, a, 2'd2};
  endfunction

  function automatic logic [W-1:0] rand_leaf();
    int k = $urandom_range(0, 3);
    if (k == 0) return '0;
    if (k == 3) return {{(W-2){1'b0}}, 2'd3};
    return mk_val($urandom);
  endfunction

  // Heap responder, stream consumer and free acceptor; all act on the falling edge.
  initial begin : env
    bit           prev_stall = 0;
    logic [W-1:0] prev_data  = '0;
    int           fr_wait    = 0;
    bus.rd_req_ready = 1'b0;
    bus.rd_rsp_valid = 1'b0;
    bus.rd_rsp_data  = '0;
    bus.o_tready     = 1'b0;
`ifdef QTREE_SER_FREE_EN
    bus.free_ready   = 1'b0;
`endif
    forever begin
      @(negedge clk);
      bus.rd_rsp_valid = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.rd_rsp_valid = 1'b1;
          bus.rd_rsp_data  = heap[pend_addr[7:0]];
        end
      end
      bus.rd_req_ready = req_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.rd_req_valid && bus.rd_req_ready) begin
        got_rd.push_back(bus.rd_req_addr);
        pend_addr = bus.rd_req_addr;
        lat_cnt   = req_rand ? $urandom_range(1, 4) : rd_lat;
      end
      if (prev_stall && bus.o_tvalid) check("tdata_stable", bus.o_tdata, prev_data);
      bus.o_tready = out_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.o_tvalid && bus.o_tready) begin
        got_w.push_back(bus.o_tdata);
        got_l.push_back(bus.o_tlast);
      end
      prev_stall = bus.o_tvalid && !bus.o_tready;
      prev_data  = bus.o_tdata;
`ifdef QTREE_SER_FREE_EN
      bus.free_ready = 1'b0;
      if (bus.free_valid) begin
        if (fr_wait < free_delay) begin
          fr_wait++;
        end else begin
          bus.free_ready = 1'b1;
          fr_wait = 0;
          got_fr.push_back(bus.free_addr);
        end
      end
`endif
    end
  end

  // Reference: postfix walk of the heap with a work list of visit/emit items.
  typedef struct { bit emit; logic [15:0] addr; int level; } item_t;

  task automatic model(input logic [15:0] root);
    item_t        st[$];
    item_t        it;
    logic [W-1:0] w;
    exp_w.delete(); exp_rd.delete(); exp_fr.delete();
    exp_ovf = 0;
    st.push_back('{0, root, 0});
    while (st.size() > 0) begin
      it = st.pop_back();
      w  = heap[it.addr[7:0]];
      if (it.emit) begin
        exp_w.push_back({{(W-2){1'b0}}, 2'd2});
        exp_fr.push_back(it.addr);
      end else begin
        exp_rd.push_back(it.addr);
        if (w[1:0] == 2'd2) begin
          if (it.level == TB_DEPTH) begin
            exp_w.push_back({{(W-2){1'b0}}, 2'd3});
            exp_ovf = 1;
            break;
          end
          st.push_back('{1, it.addr, it.level});
          for (int c = 3; c >= 0; c--) st.push_back('{0, w[2+16*c +: 16], it.level + 1});
        end else begin
          exp_w.push_back(w);
          exp_fr.push_back(it.addr);
        end
      end
    end
  endtask

  task automatic run(input logic [15:0] root, input string name, input int exp_lat);
    int n, lat;
    bit done;
    model(root);
    got_w.delete(); got_l.delete(); got_rd.delete(); got_fr.delete();
    @(negedge clk);
    bus.root_valid = 1'b1;
    bus.root_ptr   = root;
    n = 0;
    while (!bus.root_ready && n < 100) begin @(negedge clk); n++; end
    check({name, ":accept"}, bus.root_ready, 1);
    @(negedge clk);
    bus.root_valid = 1'b0;
    check({name, ":busy"}, bus.busy, 1);
    check({name, ":ovf_cleared"}, bus.overflow, 0);
    n = 1; lat = -1; done = 0;
    while (!done && n < 3000) begin
      if (lat < 0 && bus.o_tvalid) lat = n;
      if (got_l.size() > 0 && got_l[got_l.size()-1]) done = 1;
      else begin @(negedge clk); n++; end
    end
    check({name, ":done"}, done, 1);
    n = 0;
    while (!bus.root_ready && n < 50) begin @(negedge clk); n++; end
    if (exp_lat >= 0) check({name, ":latency"}, lat, exp_lat);
    check({name, ":nwords"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++) begin
      check($sformatf("%s:w%0d", name, i), (i < got_w.size()) ? got_w[i] : '1, exp_w[i]);
      check($sformatf("%s:last%0d", name, i), (i < got_l.size()) ? got_l[i] : 1'bx,
            (i == exp_w.size() - 1));
    end
    check({name, ":nreads"}, got_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
      check($sformatf("%s:rd%0d", name, i), got_rd[i], exp_rd[i]);
`ifdef QTREE_SER_FREE_EN
    check({name, ":nfrees"}, got_fr.size(), exp_ovf ? 0 : exp_fr.size());
    for (int i = 0; i < got_fr.size() && i < exp_fr.size(); i++)
      check($sformatf("%s:free%0d", name, i), got_fr[i], exp_fr[i]);
`endif
    check({name, ":overflow"}, bus.overflow, exp_ovf);
    check({name, ":idle_ready"}, bus.root_ready, 1);
    check({name, ":idle_busy"}, bus.busy, 0);
  endtask

  task automatic build_random(input logic [15:0] base);
    int nxt = base + 1;
    logic [15:0] ch[4];
    logic [15:0] gc[4];
    for (int c = 0; c < 4; c++) begin
      ch[c] = 16'(nxt); nxt++;
      if ($urandom_range(0, 2) == 2) begin
        for (int g = 0; g < 4; g++) begin
          gc[g] = 16'(nxt); nxt++;
          heap[gc[g][7:0]] = rand_leaf();
        end
        heap[ch[c][7:0]] = mk_node(gc[0], gc[1], gc[2], gc[3]);
      end else begin
        heap[ch[c][7:0]] = rand_leaf();
      end
    end
    heap[base[7:0]] = ($urandom_range(0, 4) == 0) ? rand_leaf() : mk_node(ch[0], ch[1], ch[2], ch[3]);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    bus.root_valid = 1'b0;
    bus.root_ptr   = '0;
    for (int i = 0; i < 256; i++) heap[i] = '0;
    repeat (3) @(negedge clk);
    check("rst:root_ready", bus.root_ready, 1);
    check("rst:busy", bus.busy, 0);
    check("rst:rd_req_valid", bus.rd_req_valid, 0);
    check("rst:rd_req_addr", bus.rd_req_addr, 0);
    check("rst:tvalid", bus.o_tvalid, 0);
    check("rst:tlast", bus.o_tlast, 0);
    check("rst:tdata", bus.o_tdata, 0);
    check("rst:overflow", bus.overflow, 0);
    aresetn = 1'b1;

    // Single leaf roots: latency is 2 + L cycles from root accept.
    heap[5] = mk_val(7);
    rd_lat = 1; run(5, "leaf", 3);
    check("leaf:word", got_w.size() > 0 ? got_w[0] : '0, {{(W-34){1'b0}}, 32'd7, 2'd1});
    heap[40] = mk_val(32'hdeadbeef);
    rd_lat = 3; run(40, "leaf_l3", 5);
    rd_lat = 1;

    // Four-leaf tree.
    heap[1] = mk_node(2, 3, 4, 5);
    for (int i = 0; i < 4; i++) heap[2+i] = mk_val(32'(i + 1));
    run(1, "quad", -1);
`ifdef QTREE_SER_FREE_EN
    free_delay = 3; run(1, "quad_free", -1); free_delay = 0;
`endif

    // Depth-2 tree under random backpressure and heap latency.
    heap[10] = mk_node(11, 16, 17, 18);
    heap[11] = mk_node(12, 13, 14, 15);
    for (int i = 12; i < 16; i++) heap[i] = '0;
    for (int i = 16; i < 19; i++) heap[i] = mk_val(32'(100 + i));
    out_rand = 1; req_rand = 1;
    run(10, "depth2", -1);
    check("depth2:count9", got_w.size(), 9);
    out_rand = 0; req_rand = 0;

    // Three nested QNodes exceed a 2-entry stack.
    heap[20] = mk_node(21, 2, 3, 4);
    heap[21] = mk_node(22, 2, 3, 4);
    heap[22] = mk_node(2, 3, 4, 5);
    run(20, "ovf", -1);
    check("ovf:flag", bus.overflow, 1);
    check("ovf:err_tag", got_w.size() > 0 ? got_w[got_w.size()-1][1:0] : 2'd0, 2'd3);
    run(5, "after_ovf", 3);

    // Reset while a read is outstanding; the late response must be ignored.
    rd_lat = 4;
    @(negedge clk);
    bus.root_valid = 1'b1; bus.root_ptr = 16'd1;
    n = 0;
    while (!bus.root_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.root_valid = 1'b0;
    n = 0;
    while (!bus.rd_req_valid && n < 20) begin @(negedge clk); n++; end
    check("rst_mid:req", bus.rd_req_valid, 1);
    @(negedge clk);
    aresetn = 1'b0;
    @(negedge clk);
    check("rst_mid:root_ready", bus.root_ready, 1);
    check("rst_mid:busy", bus.busy, 0);
    aresetn = 1'b1;
    got_w.delete(); got_l.delete();
    repeat (8) @(negedge clk);
    check("rst_mid:no_output", got_w.size(), 0);
    check("rst_mid:still_idle", bus.busy, 0);
    rd_lat = 1;
    run(5, "after_rst", 3);

    // Random trees.
    for (int k = 0; k < 8; k++) begin
      build_random(16'd100);
      out_rand = 1; req_rand = 1;
      run(16'd100, $sformatf("rand%0d", k), -1);
    end
    out_rand = 0; req_rand = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
